// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: steps each instruction through fetch/decode/execute/memory/writeback.
// Optional MCU_ILLEGAL_TRAP_EN: unlisted opcodes trap into a terminal ILLEGAL state with a sticky illegal_op flag.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, JAL, BEQ
`ifdef MCU_ILLEGAL_TRAP_EN
        , ILLEGAL
`endif
    } state_t;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

    state_t state, next_state;
    aluop_t aluop;
    logic   pc_update, branch;
    logic   mem_req_c, mem_write_c, ir_write_c, reg_write_c, instr_done_c;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

`ifdef MCU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                        illegal_op <= 1'b0;
        else if (state == DECODE && next_state == ILLEGAL) illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        aluop        = ALUOP_ADD;
        pc_update    = 1'b0;
        branch       = 1'b0;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        instr_done_c = 1'b0;
        adr_src      = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        case (state)
            FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: next_state = MEMADR;
                    7'b0110011:             next_state = EXECR;
                    7'b0010011:             next_state = EXECI;
                    7'b1101111:             next_state = JAL;
                    7'b1100011:             next_state = BEQ;
                    default: begin
`ifdef MCU_ILLEGAL_TRAP_EN
                        next_state = ILLEGAL;
`else
                        next_state   = FETCH;
                        instr_done_c = 1'b1;
`endif
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                next_state = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                result_src   = 2'b01;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                next_state   = FETCH;
            end
            MEMWRITE: begin
                mem_req_c    = 1'b1;
                adr_src      = 1'b1;
                mem_write_c  = 1'b1;
                instr_done_c = mem_ready;
                if (mem_ready) next_state = FETCH;
            end
            EXECR: begin
                alu_src_a  = 2'b10;
                aluop      = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                aluop      = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                next_state   = FETCH;
            end
            BEQ: begin
                alu_src_a    = 2'b10;
                aluop        = ALUOP_SUB;
                branch       = 1'b1;
                instr_done_c = 1'b1;
                next_state   = FETCH;
            end
`ifdef MCU_ILLEGAL_TRAP_EN
            ILLEGAL: next_state = ILLEGAL;
`endif
            default: next_state = FETCH;
        endcase
    end

    // Strobes are masked during reset so an aborted instruction never commits a write.
    always_comb begin
        mem_req    = rst_n & mem_req_c;
        mem_write  = rst_n & mem_write_c;
        ir_write   = rst_n & ir_write_c;
        pc_write   = rst_n & (pc_update | (branch & zero));
        reg_write  = rst_n & reg_write_c;
        instr_done = rst_n & instr_done_c;
    end

    always_comb begin
        case (op)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    // Subtract only applies to R-type (op[5]); addi with IR[30] set is still an add.
    always_comb begin
        alu_control = 3'b000;
        case (aluop)
            ALUOP_SUB: alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

endmodule
